// File: rtl/lowp_pkg.sv
// Shared definitions for the low-pass decimator: sample width and type,
// control state encoding and a constant-evaluable ceil(log2) helper.
package lowp_pkg;

    localparam int DATA_W = 28;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lowp_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// The head entry is presented combinationally from the storage array; an empty FIFO reads as zero.
module lowp_sync_fifo
    import lowp_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int DEPTH = 16
) (
    input  logic                    clock_in,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [clog2(DEPTH):0]   level
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is still taken.
    assign do_push = push && (!full || do_pop);
    assign level   = level_reg;
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clock_in) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/lowp_decimator.sv
// Discards the upstream filter's settling transient, then block-averages 2^k samples
// per output (floor shift) and queues results in a FWFT FIFO on a valid/ready stream.
module lowp_decimator
    import lowp_pkg::*;
#(
    parameter int DATA_W     = lowp_pkg::DATA_W,
    parameter int LOG2_RMAX  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int SETTLE     = 1024
) (
    input  logic                                 clock_in,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic signed [DATA_W-1:0]             signal_in,
    input  logic [3:0]                           decim_log2,
    output logic signed [DATA_W-1:0]             m_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [lowp_pkg::clog2(FIFO_DEPTH):0] fifo_level,
    output logic                                 overflow,
    output logic                                 settled
);

    localparam int AW  = DATA_W + LOG2_RMAX;
    localparam int PW  = (LOG2_RMAX > 0) ? LOG2_RMAX : 1;
    localparam int WCW = clog2(SETTLE + 2);

    state_t                   state_reg;
    state_t                   state_next;
    logic [WCW-1:0]           warm_cnt_reg;
    logic [PW-1:0]            phase_reg;
    logic [3:0]               k_reg;
    logic [3:0]               k_clamped;
    logic [3:0]               k_cur;
    logic signed [AW-1:0]     acc_reg;
    logic signed [AW-1:0]     acc_base;
    logic signed [AW-1:0]     sample_ext;
    logic signed [AW-1:0]     sum;
    logic signed [DATA_W-1:0] result_reg;
    logic                     push_reg;
    logic                     overflow_reg;
    logic                     warm_done;
    logic                     block_last;
    logic                     fifo_empty;
    logic                     fifo_full;

    assign k_clamped  = (decim_log2 > 4'(LOG2_RMAX)) ? 4'(LOG2_RMAX) : decim_log2;
    // The first sample of a block uses the live k; the rest use the value latched with it.
    assign k_cur      = (phase_reg == '0) ? k_clamped : k_reg;
    assign block_last = (phase_reg == ((PW'(1) << k_cur) - PW'(1)));
    assign sample_ext = AW'(signal_in);
    assign acc_base   = (phase_reg == '0) ? '0 : acc_reg;
    assign sum        = acc_base + sample_ext;
    assign warm_done  = (SETTLE == 0) || (enable && (warm_cnt_reg == WCW'(SETTLE - 1)));

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_reg <= WARMUP;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WARMUP:  if (warm_done) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = WARMUP;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            warm_cnt_reg <= '0;
            phase_reg    <= '0;
            k_reg        <= '0;
            acc_reg      <= '0;
            result_reg   <= '0;
            push_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            push_reg <= 1'b0;
            if (state_reg == WARMUP) begin
                if (enable) begin
                    warm_cnt_reg <= warm_cnt_reg + WCW'(1);
                end
            end else if (enable) begin
                if (phase_reg == '0) begin
                    k_reg <= k_clamped;
                end
                acc_reg <= sum;
                if (block_last) begin
                    result_reg <= DATA_W'(sum >>> k_cur);
                    push_reg   <= 1'b1;
                    phase_reg  <= '0;
                end else begin
                    phase_reg <= phase_reg + PW'(1);
                end
            end
            // Full implies non-empty, so m_ready alone tells whether a pop frees a slot.
            if (push_reg && fifo_full && !m_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    lowp_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_in  (clock_in),
        .reset     (reset),
        .push      (push_reg),
        .push_data (result_reg),
        .pop       (m_ready),
        .rd_data   (m_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    assign m_valid  = !fifo_empty;
    assign overflow = overflow_reg;
    assign settled  = (state_reg == RUN);

endmodule

// File: doc/lowp_decimator.md
# lowp_decimator

Downstream stage of the 28-bit boxcar low-pass filter: it consumes the filtered stream, discards the filter's settling transient, and block-averages R = 2^k consecutive samples into one output. Results are buffered in a small FIFO and presented on a valid/ready stream to the readout logic. It converts the full-rate filtered signal into a decimated, flow-controlled sample stream on the Red Pitaya.

## Interface
Parameters:
- DATA_W, 28: sample width, signed.
- LOG2_RMAX, 8: maximum k; the accumulator is DATA_W+LOG2_RMAX bits.
- FIFO_DEPTH, 16: output FIFO entries; must be a power of 2.
- SETTLE, 1024: number of enabled input samples discarded after reset; equals the upstream filter length.

Ports:
- clock_in  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  input qualifier; signal_in is a sample only on cycles where enable=1.
- signal_in  in  DATA_W  signed filtered sample.
- decim_log2  in  4  k; values above LOG2_RMAX are clamped to LOG2_RMAX.
- m_data  out  DATA_W  signed averaged sample at the FIFO head.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts m_data.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when a result is dropped.
- settled  out  1  warm-up complete.

## Operation
- Clock is clock_in. Reset is synchronous and active-high on `reset`.
- State WARMUP (after reset): count enabled samples and discard them. On the SETTLE-th enabled sample, go to RUN; settled goes to 1 at the same edge. With SETTLE=0, the block enters RUN immediately after reset.
- State RUN: a phase counter counts enabled samples within a block.
  - k is latched at each sample with phase==0 and held for the whole block. Changes to decim_log2 in mid-block take effect at the next block.
  - On phase 0: acc <= signal_in. On other phases: acc <= acc + signal_in.
  - On phase R-1: result <= (acc + signal_in) >>> k, a push request is raised, and phase returns to 0.
- Arithmetic:
  - Inputs are sign-extended to the accumulator width, so the sum cannot wrap.
  - The shift is arithmetic (floor, toward -inf), with no rounding.
  - The result is always representable in DATA_W bits.
- With k=0, every enabled sample produces one result.
- FIFO behaviour:
  - First-word-fall-through: m_data is the head entry and is stable while m_valid=1 and m_ready=0.
  - A pop occurs when m_valid && m_ready.
- Push when full:
  - Full with no pop in the same cycle: the result is dropped and overflow is set to 1 until reset.
  - Full with a pop in the same cycle: the push is accepted and the level is unchanged.
- A push and a pop in the same cycle with a non-empty FIFO leave the level unchanged and keep data in order.
- enable=0 in mid-block freezes acc and phase; no timeout applies.
- Reset mid-operation flushes everything: FIFO contents, acc, phase, warm-up counter, overflow, settled, and the state returns to WARMUP.

## Timing
- Reset values: m_valid=0, m_data=0, fifo_level=0, overflow=0, settled=0, state=WARMUP.
- Latency: m_valid=1 with the new result follows 2 edges after the edge that samples the last input of a block (FIFO initially empty). This breaks down as result register (edge 1), then FIFO write (edge 2).
- fifo_level and overflow update on the edge of the push or pop that changes them.
- Throughput: one result per R enabled samples. With k=0, enable=1 and m_ready=1, the block sustains one output per cycle with no drops.
- Whether m_ready is registered or combinational: m_data/m_valid do not depend combinationally on m_ready.

## Structure
- Shared package lowp_pkg holds:
  - the DATA_W constant,
  - the signed sample typedef,
  - the clog2 function,
  - the WARMUP/RUN state encoding.
- Sub-module lowp_sync_fifo: a parameterized FWFT synchronous FIFO with level output, full/empty flags and synchronous reset.
- The top level holds the warm-up counter, phase/accumulator, k latch, result register and overflow logic.

## Test plan
- Settle: SETTLE=16, k=0, signal_in=1000, enable=1 → no m_valid and settled=0 for the first 16 samples; then settled=1 and m_data=1000 every cycle.
- Averaging: k=2, inputs 1..8 → outputs 2 then 6. Inputs -1,-1,-1,-2 → output -2 (floor of -1.25).
- Full scale: k=8, 256 samples of -2^27 → output -2^27. 256 samples of 2^27-1 → output 2^27-1. No wrap in either case.
- Backpressure: k=0, m_ready=0, 20 samples 0..19 → fifo_level=16, overflow=1, m_data held at 0. Then m_ready=1 → outputs 0..15 in order, and overflow stays 1.
- k change mid-block: k=2, switch to k=0 after the 2nd sample of a block → that block completes as a 4-sample average; following samples emerge individually.
- Reset mid-run with FIFO level 5 → after the reset edge, m_valid=0, fifo_level=0, overflow=0, settled=0, and warm-up restarts from 0.
